// File: rtl/seq_alu_stage.sv
// rtl/seq_alu_stage.sv - sequential ALU stage: single-cycle ops plus an n-cycle shift-add multiply
// Handshaked in/out; results held in DONE until the downstream consumes them.
module seq_alu_stage #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   opcode,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] out0,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         carry,
  output logic         zero,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                         OP_XOR = 3'b100, OP_SLT = 3'b101, OP_MUL = 3'b110;

  state_t        state_q;
  logic [n-1:0]  out0_q, mcand_q, mplier_q, acc_q;
  logic          carry_q, zero_q;
  logic [CW-1:0] cnt_q;

  logic [n:0]    sum_d, diff_d;
  logic [n-1:0]  res_d, acc_d;
  logic          carry_d;

  always_comb begin
    sum_d   = {1'b0, a} + {1'b0, b};
    diff_d  = {1'b0, a} - {1'b0, b};
    res_d   = '0;
    carry_d = 1'b0;
    case (opcode)
      OP_ADD: begin res_d = sum_d[n-1:0];  carry_d = sum_d[n];  end
      // diff_d[n] is the borrow, so no borrow means a >= b unsigned
      OP_SUB: begin res_d = diff_d[n-1:0]; carry_d = ~diff_d[n]; end
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_SLT: res_d[0] = ($signed(a) < $signed(b));
      OP_MUL: res_d = '0;
      default: res_d = b;
    endcase
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      out0_q   <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (opcode == OP_MUL) begin
              mcand_q  <= a;
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= EXEC;
            end else begin
              out0_q  <= res_d;
              carry_q <= carry_d;
              zero_q  <= (res_d == '0);
              state_q <= DONE;
            end
          end
        end
        EXEC: begin
          // out0 is only written on the final iteration so no partial product leaks out
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          acc_q    <= acc_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            out0_q  <= acc_d;
            carry_q <= 1'b0;
            zero_q  <= (acc_d == '0);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == EXEC);
  assign out_valid = (state_q == DONE);
  assign out0      = out0_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_alu_stage.sv
// tb/tb_seq_alu_stage.sv - self-checking bench for seq_alu_stage with a result scoreboard
module tb_seq_alu_stage;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, carry, zero, busy;
  logic [2:0]   opcode;
  logic [N-1:0] a, b, out0;

  int           checks = 0;
  int           failures = 0;
  int           pops = 0;
  logic [17:0]  sbq[$];
  logic [17:0]  last_exp = '0;

  always #5 clk = ~clk;

  seq_alu_stage #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out0(out0), .out_valid(out_valid),
    .out_ready(out_ready), .carry(carry), .zero(zero), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {zero, carry, result} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    longint xu, yu, sx, sy;
    logic [15:0] r;
    logic c;
    xu = longint'({48'b0, x});
    yu = longint'({48'b0, y});
    sx = (xu >= 32768) ? xu - 65536 : xu;
    sy = (yu >= 32768) ? yu - 65536 : yu;
    r = '0;
    c = 1'b0;
    case (op)
      3'd0: begin r = 16'((xu + yu) % 65536); c = (xu + yu) >= 65536; end
      3'd1: begin r = 16'((xu - yu + 65536) % 65536); c = (xu >= yu); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = (sx < sy) ? 16'd1 : 16'd0;
      3'd6: r = 16'((xu * yu) % 65536);
      default: r = y;
    endcase
    return {(r == 16'd0), c, r};
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("status_onehot", $countones({in_ready, busy, out_valid}), 1);
      if (out_valid === 1'b1) begin
        if (sbq.size() == 0) chk("result_expected", sbq.size(), 1);
        else begin
          chk("sb_out0", 32'(out0), 32'(sbq[0][15:0]));
          chk("sb_carry", 32'(carry), 32'(sbq[0][16]));
          chk("sb_zero", 32'(zero), 32'(sbq[0][17]));
          last_exp = sbq[0];
          if (out_ready === 1'b1) begin
            void'(sbq.pop_front());
            pops++;
          end
        end
      end else begin
        chk("out0_hold", 32'(out0), 32'(last_exp[15:0]));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    opcode = op; a = x; b = y; in_valid = 1'b1;
    chk("accept_ready", 32'(in_ready), 1);
    sbq.push_back(model(op, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int bc);
    cyc = 0; bc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      bc += int'(busy);
      in_valid = cyc[0];
      opcode = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
      cyc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    int cyc, bc;
    out_ready = 1'b1;
    issue(op, x, y);
    wait_done(cyc, bc);
    chk("latency", cyc, (op == 3'd6) ? N : 0);
    chk("busy_cycles", bc, (op == 3'd6) ? N : 0);
    @(posedge clk); #1;
    chk("back_to_idle", 32'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, bc, p0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out0", 32'(out0), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    issue(3'd0, 16'hFFFF, 16'h0001);
    chk("add_wrap_out0", 32'(out0), 32'h0000);
    chk("add_wrap_carry", 32'(carry), 1);
    chk("add_wrap_zero", 32'(zero), 1);
    chk("add_wrap_valid", 32'(out_valid), 1);
    consume();

    issue(3'd1, 16'd5, 16'd7);
    chk("sub_out0", 32'(out0), 32'hFFFE);
    chk("sub_carry", 32'(carry), 0);
    chk("sub_zero", 32'(zero), 0);
    consume();
    issue(3'd5, 16'h8000, 16'h0001);
    chk("slt_out0", 32'(out0), 32'h0001);
    consume();

    issue(3'd6, 16'd300, 16'd300);
    wait_done(cyc, bc);
    chk("mul_latency", cyc, 16);
    chk("mul_busy", bc, 16);
    chk("mul_out0", 32'(out0), 32'h5F90);
    chk("mul_carry", 32'(carry), 0);
    chk("mul_valid", 32'(out_valid), 1);
    consume();

    issue(3'd0, 16'd3, 16'd4);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; opcode = 3'd1; a = 16'd9; b = 16'd1;
      chk("hold_out0", 32'(out0), 32'h0007);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(in_ready), 1);
    chk("release_valid", 32'(out_valid), 0);
    out_ready = 1'b0;

    run_op(3'd2, 16'hF0F0, 16'h0FF0);
    run_op(3'd3, 16'h1200, 16'h0034);
    run_op(3'd4, 16'hAAAA, 16'hAAAA);
    run_op(3'd7, 16'h1234, 16'hBEEF);
    run_op(3'd5, 16'h0001, 16'h8000);
    run_op(3'd5, 16'hFFFF, 16'h0000);
    run_op(3'd1, 16'd7, 16'd7);
    run_op(3'd1, 16'd0, 16'd1);
    run_op(3'd0, 16'h8000, 16'h8000);
    run_op(3'd6, 16'hFFFF, 16'hFFFF);
    run_op(3'd6, 16'h0000, 16'h1234);
    run_op(3'd6, 16'd7, 16'd9);

    issue(3'd6, 16'd1234, 16'd5678);
    repeat (7) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    sbq.delete();
    last_exp = '0;
    #1;
    chk("abort_out0", 32'(out0), 0);
    chk("abort_carry", 32'(carry), 0);
    chk("abort_zero", 32'(zero), 0);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(3'd0, 16'd1, 16'd1);
    chk("post_reset_add", 32'(out0), 32'h0002);
    consume();

    p0 = pops;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(3'd0, 16'(i * 4099), 16'(i * 7 + 65530));
      chk("stream_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
      chk("stream_gap", 32'(out_valid), 0);
      chk("stream_ready", 32'(in_ready), 1);
    end
    out_ready = 1'b0;
    chk("stream_results", pops - p0, 8);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu_stage.md
SEQ_ALU_STAGE -- requirements
Module: seq_alu_stage

Interface
REQ-001 The block SHALL have parameter n, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-006 The block SHALL have port opcode, input, 3 bits: the operation select.
REQ-007 The block SHALL have ports a and b, input, n bits each: the operands.
REQ-008 The block SHALL have port out0, output, n bits: the registered result, which drives in0 of the downstream N-bit register.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out0 holds a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the result.
REQ-011 The block SHALL have ports carry and zero, output, 1 bit each: the result flags.
REQ-012 The block SHALL have port busy, output, 1 bit: a multiply is in progress.

Function
REQ-013 The block SHALL implement the FSM states IDLE, EXEC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 out_valid SHALL be 1 only in DONE.
REQ-016 busy SHALL be 1 only in EXEC.
REQ-017 An operand set SHALL be accepted at the rising edge where in_valid=1 and in_ready=1; a, b and opcode SHALL be sampled only at that edge.
REQ-018 The opcodes SHALL be: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SLT (signed; result 1 if a<b, else 0), 110 MUL (low n bits of a*b, unsigned), 111 PASS (out0=b).
REQ-019 For every opcode except MUL, the accept edge SHALL load out0, carry and zero, and the state SHALL go IDLE->DONE (latency 1: out_valid high immediately after the accept edge).
REQ-020 For MUL, the accept edge SHALL go IDLE->EXEC, and a shift-add iteration SHALL run over exactly n cycles, one multiplier bit per cycle, LSB first.
REQ-021 On the n-th EXEC edge the state SHALL go EXEC->DONE and out0 SHALL load the product: out_valid rises exactly n cycles after the accept edge.
REQ-022 out0 SHALL NOT change during EXEC; it SHALL keep its previous value.
REQ-023 carry SHALL be: for ADD, the carry out of bit n-1; for SUB, 1 when a>=b unsigned (no borrow); for all other opcodes, 0.
REQ-024 zero SHALL be 1 exactly when the new out0 equals 0; it SHALL be updated on the same edge as out0.
REQ-025 All arithmetic SHALL wrap modulo 2^n; no overflow flag SHALL exist.
REQ-026 In DONE, out0, carry and zero SHALL hold stable until an edge with out_ready=1; that edge SHALL move the state to IDLE and clear out_valid.
REQ-027 When out_ready=1 in the same cycle out_valid rises, the result SHALL be consumed on the next edge (minimum one cycle in DONE).
REQ-028 in_valid while in_ready=0 (in EXEC or DONE) SHALL be ignored and SHALL NOT corrupt an operation in progress.
REQ-029 An opcode or operand change during EXEC SHALL have no effect on the result.
REQ-030 Back-to-back operations SHALL be possible at one result per 2 cycles for non-MUL opcodes (accept, DONE consumed, IDLE accept).

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, out0=0, carry=0, zero=0, out_valid=0, busy=0, in_ready=1, and clear the internal multiply registers.
REQ-032 A reset during EXEC or DONE SHALL abort the operation and discard its result; no partial result SHALL appear on out0.
REQ-033 The first accept SHALL be possible on the first rising edge after rst_n returns to 1.

Verification (n=16)
REQ-034 ADD a=0xFFFF, b=0x0001 -> one cycle later out0=0x0000, carry=1, zero=1, out_valid=1.
REQ-035 SUB a=5, b=7 -> out0=0xFFFE, carry=0, zero=0; SLT a=0x8000, b=0x0001 -> out0=0x0001.
REQ-036 MUL a=300, b=300 -> busy=1 for 16 cycles, out_valid rises exactly 16 cycles after accept with out0=0x5F90 (90000 mod 65536), carry=0.
REQ-037 ADD 3+4 with out_ready=0 for 3 cycles, and in_valid pulsing with a new opcode -> out0=0x0007 held for 3 cycles, in_ready=0, new request ignored; out_ready=1 -> IDLE on the next edge.
REQ-038 Reset pulse at cycle 8 of a MUL -> all outputs 0 and in_ready=1 immediately; a following ADD 1+1 yields out0=0x0002.
REQ-039 A stream of 8 ADD operations with out_ready tied to 1 -> 8 correct results, each out_valid lasting exactly one cycle, one result per 2 cycles.
